// File: rtl/aes_enc_iter.sv
//-----------------------------------------------------------------------------
// aes_enc_iter
//
// Iterative AES-128 encryptor. One round is spread over 16/SBOX_LANES
// cycles: each cycle substitutes SBOX_LANES bytes of the state into a
// sub buffer. The last pass of a round finishes the substitution, then
// applies ShiftRows, MixColumns (skipped in round 10) and the freshly
// expanded round key in the same cycle.
//
// Byte order: byte i of any 128-bit block is bits [8*i : 8*i+7].
// Bytes are column-major, so byte i sits in column i/4, row i%4.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   in_valid    plaintext/key pair offered
//   in_ready    block can accept a new pair (IDLE only)
//   key         AES-128 cipher key
//   plaintext   input block
//   out_valid   ciphertext holds a completed result (DONE only)
//   out_ready   consumer accepts ciphertext
//   ciphertext  state register, meaningful only while out_valid = 1
//   round       current round number, 0 when idle
//
// Parameter
//   SBOX_LANES  bytes substituted per cycle; legal values 4, 8, 16
//-----------------------------------------------------------------------------
module aes_enc_iter #(
    parameter int SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] key,
    input  logic [0:127] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext,
    output logic [0:3]   round
);

    localparam int         PASSES    = 16 / SBOX_LANES;
    localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIPS-197 S-box, entry n at bits [8*n : 8*n+7].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    //-------------------------------------------------------------------------
    // Round primitives
    //-------------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TABLE[{a, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
    function automatic logic [0:127] shift_rows(input logic [0:127] b);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = b[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] b);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[32*c      +: 8];
            a1 = b[32*c + 8  +: 8];
            a2 = b[32*c + 16 +: 8];
            a3 = b[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    //-------------------------------------------------------------------------
    // Registers
    //-------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [0:127]   data_q;      // AES state
    logic [0:127]   rkey_q;      // current round key
    logic [0:127]   sub_q;       // bytes substituted by earlier passes
    logic [3:0]     round_q;
    logic [1:0]     pass_q;

    logic           last_pass;
    logic           final_round;
    logic [0:127]   sub_full;
    logic [0:127]   shifted;
    logic [0:127]   round_data;
    logic [0:127]   next_key;

    assign last_pass   = (pass_q == LAST_PASS);
    assign final_round = (round_q == 4'd10);

    //-------------------------------------------------------------------------
    // Data-path S-box lanes: this pass covers bytes
    // pass*SBOX_LANES .. pass*SBOX_LANES+SBOX_LANES-1.
    //-------------------------------------------------------------------------
    logic [3:0] byte_sel [SBOX_LANES];
    logic [7:0] lane_out [SBOX_LANES];

    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        assign byte_sel[j] = 4'(int'(pass_q) * SBOX_LANES + j);
        assign lane_out[j] = sbox(data_q[{byte_sel[j], 3'b000} +: 8]);
    end

    // The last pass must see its own lanes before they reach sub_q, so the
    // complete substituted block is the register overlaid with this pass.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sub_full = sub_q;
        for (int j = 0; j < SBOX_LANES; j++) begin
            sub_full[{byte_sel[j], 3'b000} +: 8] = lane_out[j];
        end
    end

    //-------------------------------------------------------------------------
    // Key expansion: four dedicated key S-boxes on RotWord(w3).
    //-------------------------------------------------------------------------
    logic [7:0]  ks_out [4];
    logic [0:31] temp_word;
    logic [0:31] nk0, nk1, nk2, nk3;

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        assign ks_out[i] = sbox(rkey_q[8*(12 + ((i+1) % 4)) +: 8]);
    end

    assign temp_word = {ks_out[0] ^ rcon(round_q), ks_out[1], ks_out[2], ks_out[3]};
    assign nk0       = rkey_q[0:31]   ^ temp_word;
    assign nk1       = rkey_q[32:63]  ^ nk0;
    assign nk2       = rkey_q[64:95]  ^ nk1;
    assign nk3       = rkey_q[96:127] ^ nk2;
    assign next_key  = {nk0, nk1, nk2, nk3};

    assign shifted    = shift_rows(sub_full);
    assign round_data = (final_round ? shifted : mix_columns(shifted)) ^ next_key;

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    //-------------------------------------------------------------------------
    // FSM: next state
    //-------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)                 state_d = SUB;
            SUB:     if (last_pass && final_round) state_d = DONE;
            DONE:    if (out_ready)                state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // FSM: outputs
    //-------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    //-------------------------------------------------------------------------
    // Data path
    //-------------------------------------------------------------------------
    // NOTE: the data registers are cleared on reset as well, so ciphertext
    // reads 0 after reset instead of a stale or unknown block.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            rkey_q  <= '0;
            sub_q   <= '0;
            round_q <= '0;
            pass_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= plaintext ^ key;
                        rkey_q  <= key;
                        round_q <= 4'd1;
                        pass_q  <= '0;
                    end
                end
                SUB: begin
                    sub_q <= sub_full;
                    if (last_pass) begin
                        pass_q <= '0;
                        data_q <= round_data;
                        // Round 10 keeps its round number until the handoff.
                        if (!final_round) begin
                            round_q <= round_q + 4'd1;
                            rkey_q  <= next_key;
                        end
                    end else begin
                        pass_q <= pass_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) round_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ciphertext = data_q;
    assign round      = round_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
//-----------------------------------------------------------------------------
// tb_aes_enc_iter
//
// Directed bench for aes_enc_iter. Three instances (SBOX_LANES = 16, 4, 8)
// share clk/rst. Inputs change and outputs are sampled on the falling edge.
// Expected ciphertexts are the FIPS-197 known-answer vectors.
//-----------------------------------------------------------------------------
module tb_aes_enc_iter;

    localparam logic [0:127] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic [0:127] key_in    [3];
    logic [0:127] pt_in     [3];
    logic         out_ready [3];
    wire          in_ready_w  [3];
    wire          out_valid_w [3];
    wire  [0:127] ct_w        [3];
    wire  [0:3]   round_w     [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LANES = (g == 0) ? 16 : ((g == 1) ? 4 : 8);
        aes_enc_iter #(.SBOX_LANES(LANES)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready_w[g]),
            .key        (key_in[g]),
            .plaintext  (pt_in[g]),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready[g]),
            .ciphertext (ct_w[g]),
            .round      (round_w[g])
        );
    end

    function automatic int passes(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 4 : 2);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a falling edge with the instance idle. Offers one pair,
    // follows the round counter every cycle and returns at the falling edge
    // where out_valid is first seen. busy keeps in_valid high with random
    // key/plaintext for the whole operation.
    task automatic run_vec(input int u, input logic [0:127] k, input logic [0:127] p,
                           input logic [0:127] exp, input bit busy, input string tag);
        int cyc;
        bit seen;
        int exp_round;
        check({tag, "_in_ready_idle"}, in_ready_w[u], 1);
        in_valid[u] = 1'b1;
        key_in[u]   = k;
        pt_in[u]    = p;
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= 100) begin
            @(negedge clk);
            if (busy) begin
                key_in[u] = {$urandom, $urandom, $urandom, $urandom};
                pt_in[u]  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid[u] = 1'b0;
            end
            if (out_valid_w[u]) begin
                seen = 1'b1;
            end else begin
                exp_round = 1 + cyc / passes(u);
                if (exp_round > 10) exp_round = 10;
                check({tag, "_round"}, round_w[u], exp_round);
                @(posedge clk);
                cyc++;
            end
        end
        in_valid[u] = 1'b0;
        check({tag, "_latency"}, cyc, 10 * passes(u));
        check({tag, "_ct"}, ct_w[u], exp);
        check({tag, "_in_ready_done"}, in_ready_w[u], 0);
    endtask

    // Holds out_ready low for hold cycles, then hands the result off and
    // checks the return to IDLE. keep leaves out_ready asserted afterwards.
    task automatic finish_vec(input int u, input logic [0:127] exp, input int hold,
                              input bit keep, input string tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid_w[u], 1);
            check({tag, "_hold_ct"}, ct_w[u], exp);
            check({tag, "_hold_in_ready"}, in_ready_w[u], 0);
        end
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) out_ready[u] = 1'b0;
        check({tag, "_post_valid"}, out_valid_w[u], 0);
        check({tag, "_post_in_ready"}, in_ready_w[u], 1);
        check({tag, "_post_round"}, round_w[u], 0);
    endtask

    initial begin
        int hits;
        int w;
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            key_in[u]    = '0;
            pt_in[u]     = '0;
            out_ready[u] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("reset_in_ready", in_ready_w[u], 1);
            check("reset_out_valid", out_valid_w[u], 0);
            check("reset_round", round_w[u], 0);
            check("reset_ct", ct_w[u], 0);
        end
        rst = 1'b0;

        // Known-answer vectors at 16 and 4 lanes.
        run_vec(0, KEY_A, PT_A, CT_A, 1'b0, "l16_a");
        finish_vec(0, CT_A, 0, 1'b0, "l16_a");
        run_vec(1, KEY_B, PT_B, CT_B, 1'b0, "l4_b");
        finish_vec(1, CT_B, 0, 1'b0, "l4_b");

        // Back-pressure for 7 cycles, then a second vector.
        run_vec(0, KEY_A, PT_A, CT_A, 1'b0, "bp_a");
        finish_vec(0, CT_A, 7, 1'b0, "bp_a");
        run_vec(0, KEY_B, PT_B, CT_B, 1'b0, "bp_b");
        finish_vec(0, CT_B, 0, 1'b0, "bp_b");

        // Busy input: changing pairs offered throughout must be ignored.
        run_vec(2, KEY_A, PT_A, CT_A, 1'b1, "busy");
        finish_vec(2, CT_A, 0, 1'b0, "busy");
        hits = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid_w[2]) hits++;
        end
        check("busy_no_second", hits, 0);
        check("busy_idle_ready", in_ready_w[2], 1);

        // Reset in the middle of round 5.
        in_valid[1] = 1'b1;
        key_in[1]   = KEY_B;
        pt_in[1]    = PT_B;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        w = 0;
        while (round_w[1] != 4'd5 && w < 60) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        check("rst_mid_reach5", round_w[1], 5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_round", round_w[1], 0);
        check("rst_mid_valid", out_valid_w[1], 0);
        check("rst_mid_in_ready", in_ready_w[1], 1);
        check("rst_mid_ct", ct_w[1], 0);
        run_vec(1, KEY_A, PT_A, CT_A, 1'b0, "after_rst");
        finish_vec(1, CT_A, 0, 1'b0, "after_rst");

        // Back-to-back at 8 lanes with out_ready tied high.
        out_ready[2] = 1'b1;
        run_vec(2, KEY_A, PT_A, CT_A, 1'b0, "b2b_0");
        finish_vec(2, CT_A, 0, 1'b1, "b2b_0");
        run_vec(2, KEY_B, PT_B, CT_B, 1'b0, "b2b_1");
        finish_vec(2, CT_B, 0, 1'b1, "b2b_1");
        run_vec(2, KEY_A, PT_A, CT_A, 1'b0, "b2b_2");
        finish_vec(2, CT_A, 0, 1'b1, "b2b_2");
        out_ready[2] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_iter.md
AES_ENC_ITER -- requirements
Module: aes_enc_iter

Interface
REQ-001 Parameter SBOX_LANES, default 16: state bytes substituted per cycle; legal values 4, 8, 16.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  plaintext/key pair offered.
REQ-006 in_ready  output  1  block can accept a new pair.
REQ-007 key  input  [0:127]  AES-128 cipher key; byte 0 = bits 0:7, column-major per FIPS-197.
REQ-008 plaintext  input  [0:127]  input block, same byte order as key.
REQ-009 out_valid  output  1  ciphertext holds a completed result.
REQ-010 out_ready  input  1  consumer accepts ciphertext.
REQ-011 ciphertext  output  [0:127]  encrypted block, same byte order.
REQ-012 round  output  [0:3]  current round number, 0 when idle.

Function
REQ-013 FSM states SHALL be IDLE, SUB, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored and not queued.
REQ-015 Accept (in_valid & in_ready at an edge): state reg <= plaintext ^ key, round-key reg <= key, round <= 1, pass counter <= 0, go to SUB.
REQ-016 In SUB, each cycle SHALL substitute bytes pass*SBOX_LANES .. pass*SBOX_LANES+SBOX_LANES-1 of the state via SBOX_LANES instances of the existing sbox into a 128-bit sub buffer.
REQ-017 Passes per round = 16/SBOX_LANES; pass counter wraps to 0 after the last pass.
REQ-018 On the last pass, the block SHALL compute the next round key from the round-key reg (RotWord, SubWord via 4 dedicated key sboxes, rcon(round), XOR chain) and write state <= MixColumns(ShiftRows(sub)) ^ next key.
REQ-019 For round 10, MixColumns SHALL be bypassed: state <= ShiftRows(sub) ^ next key; then go to DONE with out_valid = 1.
REQ-020 Otherwise the last pass SHALL increment round and store next key in the round-key reg.
REQ-021 Latency from accept edge to out_valid high SHALL be exactly 10*(16/SBOX_LANES) cycles (10, 20, 40).
REQ-022 In DONE, ciphertext and out_valid SHALL hold stable until out_ready = 1; the edge with out_ready = 1 returns to IDLE, out_valid <= 0, round <= 0.
REQ-023 in_ready SHALL NOT be asserted in the same cycle as out_valid; earliest next accept is the cycle after the handoff edge.
REQ-024 ciphertext SHALL present the state register at all times; its content outside DONE is don't-care for consumers.
REQ-025 key and plaintext SHALL be sampled only at the accept edge; changes afterwards have no effect.

Reset
REQ-026 rst = 1 at an edge SHALL force IDLE, out_valid = 0, in_ready = 1 (next cycle), round = 0, pass counter = 0, state and round-key regs = 0; ciphertext reads 0.
REQ-027 rst SHALL override every other input, including mid-round and during DONE; in-flight result is discarded.
REQ-028 After rst deasserts, the first edge with in_valid = 1 SHALL be a legal accept.

Verification
REQ-029 SBOX_LANES=16, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
REQ-030 SBOX_LANES=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32 after 40 cycles; round steps 1..10 every 4 cycles.
REQ-031 Back-pressure: hold out_ready = 0 for 7 cycles after out_valid -> ciphertext, out_valid stable, in_ready = 0; release -> IDLE next cycle, second vector accepted and correct.
REQ-032 Busy input: in_valid held high with changing key/pt during SUB -> result matches the accepted pair only; no second result produced.
REQ-033 Reset mid-operation: rst pulse at round 5 -> next cycle round = 0, out_valid = 0, in_ready = 1; new vector then completes with correct value and full latency.
REQ-034 SBOX_LANES=8, back-to-back vectors with out_ready tied 1 -> each result at 20 cycles, one idle cycle between handoff and next accept.
